// File: rtl/cve2_sleep_ctrl.sv
// Multi-domain sleep controller: sticky fetch enable, maskable wake, idle
// hysteresis before gating, and a saturating sleep-cycle counter.

module cve2_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic en_q;

    // Enable captured while clk_i is low so clk_o never glitches in the high phase.
    always_ff @(negedge clk_i) begin
        en_q <= en_i | scan_cg_en_i;
    end

    assign clk_o = clk_i & en_q;

endmodule

module cve2_sleep_ctrl #(
    parameter int unsigned NumDomains = 2,
    parameter int unsigned NumWake    = 4,
    parameter int unsigned IdleHold   = 4,
    parameter int unsigned SleepCntW  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic                  fetch_enable_i,
    input  logic [NumDomains-1:0] busy_i,
    input  logic [NumDomains-1:0] domain_en_i,
    input  logic [NumWake-1:0]    wake_i,
    input  logic [NumWake-1:0]    wake_mask_i,
    input  logic                  debug_req_i,
    input  logic                  irq_nm_i,
    input  logic                  sleep_cnt_clr_i,
    output logic [NumDomains-1:0] clk_o,
    output logic [NumDomains-1:0] clk_en_o,
    output logic                  fetch_enable_o,
    output logic                  core_sleep_o,
    output logic                  wake_event_o,
    output logic [SleepCntW-1:0]  sleep_cnt_o
);

    localparam int unsigned HoldW = (IdleHold > 1) ? $clog2(IdleHold) : 1;

    typedef enum logic [1:0] {
        StDisabled,
        StRun,
        StHold,
        StSleep
    } state_e;

    state_e                state_q, state_d;
    logic [NumDomains-1:0] busy_q;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                  wake_event_q, wake_event_d;
    logic [SleepCntW-1:0]  sleep_cnt_q, sleep_cnt_d;

    logic any_busy;
    logic wake;
    logic clk_on;

    assign any_busy = |(busy_q & domain_en_i);
    assign wake     = debug_req_i | irq_nm_i | (|(wake_i & wake_mask_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StDisabled;
            busy_q       <= '0;
            hold_cnt_q   <= '0;
            wake_event_q <= 1'b0;
            sleep_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_i;
            hold_cnt_q   <= hold_cnt_d;
            wake_event_q <= wake_event_d;
            sleep_cnt_q  <= sleep_cnt_d;
        end
    end

    // Next-state logic; any activity always wins over idle expiry.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wake_event_d = 1'b0;
        sleep_cnt_d  = sleep_cnt_q;

        unique case (state_q)
            StDisabled: begin
                if (fetch_enable_i) state_d = StRun;
            end
            StRun: begin
                if (!(any_busy | wake)) begin
                    hold_cnt_d = '0;
                    state_d    = (IdleHold == 0) ? StSleep : StHold;
                end
            end
            StHold: begin
                if (any_busy | wake) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else if (32'(hold_cnt_q) == IdleHold - 32'd1) begin
                    state_d    = StSleep;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StSleep: begin
                if (any_busy | wake) begin
                    state_d      = StRun;
                    wake_event_d = 1'b1;
                end
            end
            default: state_d = StDisabled;
        endcase

        if (sleep_cnt_clr_i) begin
            sleep_cnt_d = '0;
        end else if (core_sleep_o && (sleep_cnt_q != {SleepCntW{1'b1}})) begin
            sleep_cnt_d = sleep_cnt_q + SleepCntW'(1);
        end
    end

    // Wake re-enables clocks in the same cycle it rises.
    assign clk_on = (state_q == StRun) | (state_q == StHold) | ((state_q == StSleep) & wake);

    assign clk_en_o       = domain_en_i & {NumDomains{clk_on}};
    assign fetch_enable_o = (state_q != StDisabled);
    assign core_sleep_o   = (state_q == StSleep) & ~wake;
    assign wake_event_o   = wake_event_q;
    assign sleep_cnt_o    = sleep_cnt_q;

    for (genvar d = 0; d < NumDomains; d++) begin : g_cg
        cve2_clock_gate u_cg (
            .clk_i        (clk_i),
            .en_i         (clk_en_o[d]),
            .scan_cg_en_i (test_en_i),
            .clk_o        (clk_o[d])
        );
    end

endmodule
